cond_exec_unit_vec: RTL and testbench
=====================================

Name: cond_exec_unit_vec

Overview:
- Execute-stage condition unit for the vector (SIMD) pipeline; parametrised successor of the scalar condition unit.
- Holds one NZCV flag register per lane and evaluates the 4-bit ARM condition field against each lane's flags, producing a per-lane execute mask.
- Gates the control signals and registers them into the Memory stage, with stall/flush support.
- Optionally bypasses freshly written flags to Decode.

Parameters:
- LANES, 4, number of SIMD lanes; each lane has an independent NZCV register (1..16).
- BRANCH_MODE, 0, branch/PCSrc condition reduction: 0 = lane 0 only, 1 = any lane true, 2 = all lanes true.
- BYPASS, 1, 1 = FlagsD shows flags being written this cycle; 0 = FlagsD shows stored flags only.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold flag registers and E/M register
- flush  in  1  kill the instruction in E: no flag write, bubble into M
- ValidE  in  1  E stage holds a real instruction
- PCSrcE  in  1  instruction writes PC
- RegWriteE  in  1  instruction writes the register file
- MemWriteE  in  1  instruction writes memory
- BranchE  in  1  branch instruction
- FlagWriteE  in  2  [1] = update NZ, [0] = update CV
- CondE  in  4  ARM condition code
- ALUFlags  in  4*LANES  per-lane NZCV from ALU; lane i occupies bits [4i+3:4i]
- FlagsD  out  4*LANES  flags for Decode stage, same packing
- LaneMaskE  out  LANES  combinational per-lane CondEx
- BranchTakenE  out  1  combinational: BranchE & ValidE & reduced CondEx & !flush
- ValidM, PCSrcM, RegWriteM, MemWriteM  out  1  registered
- LaneMaskM  out  LANES  registered lane write mask

Behaviour:
- Condition codes, evaluated per lane on the stored flags:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL(1110) true; 1111 is reserved and evaluates false in all lanes.
- go = ValidE & !flush. LaneMaskE[i] = go & CondEx[i].
- Reduced condition red: lane0 / OR / AND of CondEx, per BRANCH_MODE, gated by go.
- Flag update at posedge when !stall:
  - NZ[i] <= ALUFlags NZ if FlagWriteE[1] & LaneMaskE[i]; CV[i] likewise with FlagWriteE[0].
  - Non-enabled fields and lanes hold.
- E/M register at posedge:
  - rst: all M outputs 0.
  - else flush & !stall: bubble, all M outputs 0.
  - else stall: hold.
  - else: ValidM <= go; PCSrcM <= PCSrcE & red; RegWriteM <= RegWriteE & |LaneMaskE; MemWriteM <= MemWriteE & |LaneMaskE; LaneMaskM <= LaneMaskE.
- flush with stall asserted: E-stage flag write is suppressed; the M register holds.
- Reset: every flag register is 0000, so EQ is false and NE is true after reset. BranchTakenE and LaneMaskE are combinational and therefore 0 whenever ValidE is 0.
- Latency: masks and BranchTakenE are 0 cycles; M outputs are 1 cycle; flag registers take effect on the next cycle's CondEx.
- BYPASS=1: FlagsD[i] equals the value each field will take at the next edge (mux of ALUFlags/stored per enable). BYPASS=0: FlagsD is the stored value.
- Reset wins over stall and flush.
- No arithmetic and no wrap-around; LANES=1 must degenerate exactly to scalar behaviour for all BRANCH_MODE values.

Decomposition:
- Shared package cond_pkg holds:
  - typedef nzcv_t (4-bit struct n,z,c,v)
  - enum cond_t with the 16 codes
  - localparams BR_LANE0/BR_ANY/BR_ALL
  - function eval_cond(cond_t, nzcv_t)
- One sub-module, lane_flag_reg: per-lane NZ/CV enabled registers plus the bypass mux, instantiated LANES times with a generate loop.

Test Plan:
- Reset then CondE=0000 (EQ), ValidE=1 -> LaneMaskE=0000; CondE=0001 -> LaneMaskE=1111.
- LANES=4, ALUFlags lanes Z=1,0,1,0, FlagWriteE=11, CondE=1110 -> next cycle CondE=EQ gives LaneMaskE=0101. BranchE=1: mode0 -> BranchTakenE=1, mode1 -> 1, mode2 -> 0.
- FlagWriteE=10 with ALUFlags C=1 in all lanes -> CV unchanged (CS false next cycle); NZ updated. BYPASS=1 shows the new NZ on FlagsD in the same cycle; BYPASS=0 shows it one cycle later.
- Predicated flag write CondE=NE with lanes Z=1,0,0,0 -> only lanes 1..3 update flags; lane 0 holds.
- RegWriteE=1, stall=1 for 2 cycles -> M outputs and flags frozen. Then flush=1 -> ValidM=RegWriteM=LaneMaskM=0 and no flag change.
- CondE=1111 with any flags -> LaneMaskE=0, BranchTakenE=0. Assert rst mid-stream -> all M outputs 0 and flags 0000 at the next edge.

Source files
------------

// File: rtl/cond_pkg.sv
// Shared types and helpers for the vector condition unit: NZCV flags,
// ARM condition codes, branch-reduction modes and condition evaluation.
package cond_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'ha,
    COND_LT = 4'hb,
    COND_GT = 4'hc,
    COND_LE = 4'hd,
    COND_AL = 4'he,
    COND_NV = 4'hf
  } cond_t;

  localparam int BR_LANE0 = 0;
  localparam int BR_ANY   = 1;
  localparam int BR_ALL   = 2;

  // 1111 is reserved and never executes.
  function automatic logic eval_cond(input cond_t cond, input nzcv_t f);
    logic r;
    r = 1'b0;
    case (cond)
      COND_EQ: r = f.z;
      COND_NE: r = ~f.z;
      COND_CS: r = f.c;
      COND_CC: r = ~f.c;
      COND_MI: r = f.n;
      COND_PL: r = ~f.n;
      COND_VS: r = f.v;
      COND_VC: r = ~f.v;
      COND_HI: r = f.c & ~f.z;
      COND_LS: r = ~f.c | f.z;
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = ~f.z & (f.n == f.v);
      COND_LE: r = f.z | (f.n != f.v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_exec_unit_vec_lane_flag_reg.sv
// One lane's NZCV register with independent NZ / CV write enables and an
// optional bypass that exposes the value being written this cycle.
module lane_flag_reg
  import cond_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_nz,
  input  logic  wr_cv,
  input  nzcv_t alu_flags,
  output nzcv_t flags,
  output nzcv_t flags_d
);

  nzcv_t next_flags;

  always_comb begin
    next_flags = flags;
    if (wr_nz) begin
      next_flags.n = alu_flags.n;
      next_flags.z = alu_flags.z;
    end
    if (wr_cv) begin
      next_flags.c = alu_flags.c;
      next_flags.v = alu_flags.v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flags <= '0;
    else     flags <= next_flags;
  end

  assign flags_d = (BYPASS != 0) ? next_flags : flags;

endmodule

// File: rtl/cond_exec_unit_vec.sv
// Vector execute-stage condition unit: per-lane NZCV flags, per-lane
// execute mask, branch condition reduction and the E/M control register.
module cond_exec_unit_vec
  import cond_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int BRANCH_MODE = 0,
  parameter int BYPASS      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               ValidE,
  input  logic               PCSrcE,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               BranchE,
  input  logic [1:0]         FlagWriteE,
  input  logic [3:0]         CondE,
  input  logic [4*LANES-1:0] ALUFlags,
  output logic [4*LANES-1:0] FlagsD,
  output logic [LANES-1:0]   LaneMaskE,
  output logic               BranchTakenE,
  output logic               ValidM,
  output logic               PCSrcM,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic [LANES-1:0]   LaneMaskM
);

  logic             go;
  logic             red;
  logic             lane_any;
  logic [LANES-1:0] cond_ex;

  assign go = ValidE & ~flush;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nzcv_t stored;
    nzcv_t fd;

    // Flag writes are predicated by the lane's own condition, so a killed
    // or stalled instruction never disturbs the flags.
    lane_flag_reg #(.BYPASS(BYPASS)) u_flags (
      .clk       (clk),
      .rst       (rst),
      .wr_nz     (~stall & FlagWriteE[1] & LaneMaskE[i]),
      .wr_cv     (~stall & FlagWriteE[0] & LaneMaskE[i]),
      .alu_flags (ALUFlags[4*i +: 4]),
      .flags     (stored),
      .flags_d   (fd)
    );

    assign FlagsD[4*i +: 4] = fd;
    assign cond_ex[i]       = eval_cond(cond_t'(CondE), stored);
    assign LaneMaskE[i]     = go & cond_ex[i];
  end

  always_comb begin
    red = 1'b0;
    case (BRANCH_MODE)
      BR_ANY:  red = |cond_ex;
      BR_ALL:  red = &cond_ex;
      default: red = cond_ex[0];
    endcase
    red = red & go;
  end

  assign BranchTakenE = BranchE & red;
  assign lane_any     = |LaneMaskE;

  // ---- E / M stage boundary ----
  always_ff @(posedge clk) begin
    if (rst || (flush && !stall)) begin
      ValidM    <= 1'b0;
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      LaneMaskM <= '0;
    end else if (!stall) begin
      ValidM    <= go;
      PCSrcM    <= PCSrcE & red;
      RegWriteM <= RegWriteE & lane_any;
      MemWriteM <= MemWriteE & lane_any;
      LaneMaskM <= LaneMaskE;
    end
  end

endmodule

// File: tb/tb_cond_exec_unit_vec.sv
// Bench for cond_exec_unit_vec: three 4-lane variants (branch modes 0/1/2,
// bypass on/off) and one 1-lane variant, checked against a flag-level model.
module tb_cond_exec_unit_vec;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ValidE, PCSrcE, RegWriteE, MemWriteE, BranchE;
  logic [1:0]  FlagWriteE;
  logic [3:0]  CondE;
  logic [15:0] ALUFlags;

  logic [15:0] fd  [3];
  logic [3:0]  lm  [3];
  logic [3:0]  lmm [3];
  logic        bt  [4];
  logic        vm  [4];
  logic        pm  [4];
  logic        rm  [4];
  logic        wm  [4];
  logic [3:0]  fd3;
  logic        lm3, lmm3;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    cond_exec_unit_vec #(.LANES(4), .BRANCH_MODE(g), .BYPASS(g == 1 ? 0 : 1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ValidE(ValidE),
      .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
      .BranchE(BranchE), .FlagWriteE(FlagWriteE), .CondE(CondE),
      .ALUFlags(ALUFlags), .FlagsD(fd[g]), .LaneMaskE(lm[g]),
      .BranchTakenE(bt[g]), .ValidM(vm[g]), .PCSrcM(pm[g]),
      .RegWriteM(rm[g]), .MemWriteM(wm[g]), .LaneMaskM(lmm[g])
    );
  end

  cond_exec_unit_vec #(.LANES(1), .BRANCH_MODE(2), .BYPASS(1)) dut1l (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ValidE(ValidE),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .FlagWriteE(FlagWriteE), .CondE(CondE),
    .ALUFlags(ALUFlags[3:0]), .FlagsD(fd3), .LaneMaskE(lm3),
    .BranchTakenE(bt[3]), .ValidM(vm[3]), .PCSrcM(pm[3]),
    .RegWriteM(rm[3]), .MemWriteM(wm[3]), .LaneMaskM(lmm3)
  );

  // Reference state: per-lane flags and per-DUT M register contents.
  logic [3:0] mf [4];
  logic       mv [4];
  logic       mp [4];
  logic       mr [4];
  logic       mw [4];
  logic [3:0] ml [4];
  int checks = 0;
  int errors = 0;

  // Conditions come in true/inverted pairs selected by the low code bit.
  function automatic logic cond_ok(input int code, input logic [3:0] f);
    logic n, z, c, v, b;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code >> 1)
      0: b = z;
      1: b = c;
      2: b = n;
      3: b = v;
      4: b = c && !z;
      5: b = (n == v);
      6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    if (code == 15) return 1'b0;
    if (code == 14) return 1'b1;
    return (code % 2 == 1) ? !b : b;
  endfunction

  function automatic logic reduce(input int mode, input logic [3:0] ce, input int nl);
    int cnt;
    cnt = 0;
    for (int i = 0; i < nl; i++) cnt += ce[i];
    if (mode == 0) return ce[0];
    if (mode == 1) return cnt > 0;
    return cnt == nl;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, f, v, p, rw, mw, b,
                       input logic [1:0] fw, input logic [3:0] c, input logic [15:0] a);
    rst = r; stall = s; flush = f; ValidE = v; PCSrcE = p; RegWriteE = rw;
    MemWriteE = mw; BranchE = b; FlagWriteE = fw; CondE = c; ALUFlags = a;
  endtask

  // One pipeline cycle: check combinational outputs, clock, advance model, check M.
  task automatic cyc;
    logic       go;
    logic [3:0] ce, mask, msk, nf [4];
    int         mode, nl;
    #1;
    go = ValidE && !flush;
    for (int i = 0; i < 4; i++) begin
      ce[i]   = cond_ok(CondE, mf[i]);
      mask[i] = go && ce[i];
      nf[i]   = mf[i];
      if (!stall && FlagWriteE[1] && mask[i]) nf[i][3:2] = ALUFlags[4*i+2 +: 2];
      if (!stall && FlagWriteE[0] && mask[i]) nf[i][1:0] = ALUFlags[4*i +: 2];
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("LaneMaskE[%0d]", d), lm[d], mask);
      chk($sformatf("BranchTakenE[%0d]", d), bt[d], BranchE && go && reduce(d, ce, 4));
      chk($sformatf("FlagsD[%0d]", d), fd[d],
          d == 1 ? {mf[3], mf[2], mf[1], mf[0]} : {nf[3], nf[2], nf[1], nf[0]});
    end
    chk("LaneMaskE[1L]", lm3, mask[0]);
    chk("BranchTakenE[1L]", bt[3], BranchE && go && ce[0]);
    chk("FlagsD[1L]", fd3, nf[0]);
    @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      nl   = (d == 3) ? 1 : 4;
      mode = (d == 3) ? 2 : d;
      msk  = (d == 3) ? {3'b000, mask[0]} : mask;
      if (rst || (flush && !stall)) begin
        mv[d] = 0; mp[d] = 0; mr[d] = 0; mw[d] = 0; ml[d] = 0;
      end else if (!stall) begin
        mv[d] = go;
        mp[d] = PCSrcE && go && reduce(mode, ce, nl);
        mr[d] = RegWriteE && (msk != 0);
        mw[d] = MemWriteE && (msk != 0);
        ml[d] = msk;
      end
    end
    for (int i = 0; i < 4; i++) mf[i] = rst ? 4'h0 : nf[i];
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("ValidM[%0d]", d), vm[d], mv[d]);
      chk($sformatf("PCSrcM[%0d]", d), pm[d], mp[d]);
      chk($sformatf("RegWriteM[%0d]", d), rm[d], mr[d]);
      chk($sformatf("MemWriteM[%0d]", d), wm[d], mw[d]);
      chk($sformatf("LaneMaskM[%0d]", d), d == 3 ? {3'b000, lmm3} : lmm[d], ml[d]);
    end
  endtask

  typedef struct {
    logic [1:0]  fw;
    logic [3:0]  cond;
    logic        branch;
    logic [15:0] alu;
    logic [3:0]  exp_mask;
    logic [2:0]  exp_br;   // {mode2, mode1, mode0}
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{2'b00, 4'h0, 1'b0, 16'h0000, 4'b0000, 3'b000}; // EQ after reset
    vecs[1] = '{2'b00, 4'h1, 1'b0, 16'h0000, 4'b1111, 3'b000}; // NE after reset
    vecs[2] = '{2'b11, 4'he, 1'b0, 16'h0404, 4'b1111, 3'b000}; // Z=1,0,1,0
    vecs[3] = '{2'b00, 4'h0, 1'b1, 16'h0000, 4'b0101, 3'b011}; // EQ + branch
    vecs[4] = '{2'b10, 4'he, 1'b0, 16'haaaa, 4'b1111, 3'b000}; // NZ only, C=1 ignored
    vecs[5] = '{2'b00, 4'h2, 1'b1, 16'h0000, 4'b0000, 3'b000}; // CS still false
    vecs[6] = '{2'b10, 4'he, 1'b0, 16'h0004, 4'b1111, 3'b000}; // lane0 Z=1 only
    vecs[7] = '{2'b11, 4'h1, 1'b0, 16'hffff, 4'b1110, 3'b000}; // predicated write
    vecs[8] = '{2'b00, 4'h4, 1'b1, 16'h0000, 4'b1110, 3'b010}; // MI: lane0 held
    vecs[9] = '{2'b00, 4'hf, 1'b1, 16'hffff, 4'b0000, 3'b000}; // reserved code

    for (int i = 0; i < 4; i++) begin
      mf[i] = 0; mv[i] = 0; mp[i] = 0; mr[i] = 0; mw[i] = 0; ml[i] = 0;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc();

    foreach (vecs[k]) begin
      drive(0, 0, 0, 1, 1, 1, 0, vecs[k].branch, vecs[k].fw, vecs[k].cond, vecs[k].alu);
      #1;
      chk($sformatf("vec%0d mask", k), lm[0], vecs[k].exp_mask);
      for (int d = 0; d < 3; d++)
        chk($sformatf("vec%0d taken mode%0d", k, d), bt[d], vecs[k].exp_br[d]);
      cyc();
    end

    // Stall holds the M register and the flags, then a flush leaves a bubble.
    drive(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 4'he, 16'h0000);
    cyc();
    drive(0, 1, 0, 1, 0, 0, 1, 0, 2'b11, 4'he, 16'h0000);
    cyc();
    cyc();
    chk("stall RegWriteM held", rm[0], 1'b1);
    chk("stall LaneMaskM held", lmm[0], 4'b1111);
    drive(0, 0, 1, 1, 0, 1, 0, 0, 2'b11, 4'he, 16'h0000);
    cyc();
    chk("flush ValidM", vm[0], 1'b0);
    chk("flush LaneMaskM", lmm[0], 4'b0000);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h4, 16'h0000);
    #1;
    chk("flags survive stall/flush", lm[0], 4'b1110);
    cyc();

    // Flush during stall: no flag write and M holds.
    drive(0, 1, 1, 1, 0, 1, 0, 0, 2'b11, 4'he, 16'h0000);
    cyc();

    // Reset mid-stream beats a concurrent flag write.
    drive(1, 1, 0, 1, 1, 1, 1, 1, 2'b11, 4'he, 16'hffff);
    cyc();
    chk("rst ValidM", vm[2], 1'b0);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 4'h1, 16'h0000);
    #1;
    chk("rst flags cleared", lm[0], 4'b1111);
    cyc();

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            2'($urandom), 4'($urandom), 16'($urandom));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
